// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the N_MAC dot-product path.
//   - datapath sizing: D_LEN, CELL_N, DWIDTH, MULT_LAT
//   - IEEE-754 single field layout and bias
//   - feeder FSM state encoding
//   - fmul(): single-cycle reference of the truncating float multiply
package mac_pkg;

  localparam int D_LEN    = 32;
  localparam int CELL_N   = 8;
  localparam int DWIDTH   = CELL_N * D_LEN;
  localparam int MULT_LAT = 3;

  localparam int SIGN_BIT = 31;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = FRAC_W + 1;
  localparam int EXPX_W   = EXP_W + 2;  // signed exponent with headroom for ea+eb+1
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_FIRE      = 3'd2,
    ST_WAIT_LOW  = 3'd3,
    ST_WAIT_HIGH = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  // Float multiply: denormals flushed, NaN/overflow saturate to signed
  // infinity, mantissa truncated after a one-bit normalisation.
  function automatic logic [D_LEN-1:0] fmul(input logic [D_LEN-1:0] a,
                                            input logic [D_LEN-1:0] b);
    logic                    sgn;
    logic [EXP_W-1:0]        ea;
    logic [EXP_W-1:0]        eb;
    logic [2*MANT_W-1:0]     prod;
    logic [FRAC_W-1:0]       frac;
    logic signed [EXPX_W-1:0] exp_s;
    logic [D_LEN-1:0]        res;
    sgn  = a[SIGN_BIT] ^ b[SIGN_BIT];
    ea   = a[FRAC_W +: EXP_W];
    eb   = b[FRAC_W +: EXP_W];
    prod = {{MANT_W{1'b0}}, 1'b1, a[FRAC_W-1:0]} * {{MANT_W{1'b0}}, 1'b1, b[FRAC_W-1:0]};
    // Product of two [1,2) mantissas lies in [1,4): top bit selects the shift.
    frac = prod[2*MANT_W-1] ? prod[2*MANT_W-2 -: FRAC_W] : prod[2*MANT_W-3 -: FRAC_W];
    exp_s = $signed({2'b00, ea}) + $signed({2'b00, eb})
          + $signed({{(EXPX_W-1){1'b0}}, prod[2*MANT_W-1]})
          - $signed(EXPX_W'(EXP_BIAS));
    if ((ea == {EXP_W{1'b0}}) || (eb == {EXP_W{1'b0}})) begin
      res = {sgn, {(D_LEN-1){1'b0}}};
    end else if ((ea == {EXP_W{1'b1}}) || (eb == {EXP_W{1'b1}})) begin
      res = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (exp_s >= $signed(EXPX_W'(EXP_MAX))) begin
      res = {sgn, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (exp_s <= $signed(EXPX_W'(0))) begin
      res = {sgn, {(D_LEN-1){1'b0}}};
    end else begin
      res = {sgn, exp_s[EXP_W-1:0], frac};
    end
    return res;
  endfunction

endpackage

// File: rtl/float_mult.sv
// float_mult: LAT-stage pipelined IEEE-754 single multiplier.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (valid bits only)
//   a, b            - operands
//   in_valid/in_tag - operand pair strobe and its lane index
//   out_valid/out_tag/out_p - product, delayed by LAT cycles
module float_mult import mac_pkg::*; #(
  parameter int LAT   = MULT_LAT,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [D_LEN-1:0] a,
  input  logic [D_LEN-1:0] b,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [D_LEN-1:0] out_p
);

  logic [D_LEN-1:0]            prod_s;
  logic [LAT-1:0]              valid_r;
  logic [LAT-1:0][TAG_W-1:0]   tag_r;
  logic [LAT-1:0][D_LEN-1:0]   data_r;

  assign prod_s = fmul(a, b);

  // Valid bits: reset so in-flight products are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  // Data and tag shift register; contents are meaningless without valid.
  always_ff @(posedge clk) begin
    data_r[0] <= prod_s;
    tag_r[0]  <= in_tag;
    for (int i = 1; i < LAT; i++) begin
      data_r[i] <= data_r[i-1];
      tag_r[i]  <= tag_r[i-1];
    end
  end

  assign out_valid = valid_r[LAT-1];
  assign out_tag   = tag_r[LAT-1];
  assign out_p     = data_r[LAT-1];

endmodule

// File: rtl/n_mult_feeder.sv
// n_mult_feeder: multiplies a serial stream of float pairs, packs up to
// CELL_N products into one lane word for the adder array, triggers the
// accumulation and returns the scalar result.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   a_in, b_in, in_valid, in_last, in_ready - operand pair stream
//   mult_out, mult_wen       - lane word to the adder array (one-cycle pulse)
//   acc_start, acc_finish, acc_out - accumulation handshake and result
//   res_out, res_valid, res_last   - batch result strobe
module n_mult_feeder #(
  parameter int D_LEN    = 32,
  parameter int CELL_N   = 8,
  parameter int MULT_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [D_LEN-1:0]         a_in,
  input  logic [D_LEN-1:0]         b_in,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [CELL_N*D_LEN-1:0]  mult_out,
  output logic                     mult_wen,
  output logic                     acc_start,
  input  logic                     acc_finish,
  input  logic [D_LEN-1:0]         acc_out,
  output logic [D_LEN-1:0]         res_out,
  output logic                     res_valid,
  output logic                     res_last
);

  import mac_pkg::state_e;
  import mac_pkg::ST_LOAD;
  import mac_pkg::ST_DRAIN;
  import mac_pkg::ST_FIRE;
  import mac_pkg::ST_WAIT_LOW;
  import mac_pkg::ST_WAIT_HIGH;
  import mac_pkg::ST_DONE;

  localparam int DWIDTH = CELL_N * D_LEN;
  localparam int TAG_W  = (CELL_N > 1) ? $clog2(CELL_N) : 1;
  localparam int DR_W   = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_e                         state_r;
  logic [TAG_W-1:0]               cnt_r;
  logic [DR_W-1:0]                drain_r;
  logic                           last_r;
  logic [CELL_N-1:0][D_LEN-1:0]   lane_r;

  logic                           accept_s;
  logic                           close_s;
  logic                           pv_s;
  logic [TAG_W-1:0]               ptag_s;
  logic [D_LEN-1:0]               pprod_s;

  assign accept_s = in_valid & in_ready;
  assign close_s  = accept_s & (in_last | (cnt_r == TAG_W'(CELL_N - 1)));

  float_mult #(.LAT(MULT_LAT), .TAG_W(TAG_W)) u_mult (
    .clk       (clk),
    .rst       (rst),
    .a         (a_in),
    .b         (b_in),
    .in_valid  (accept_s),
    .in_tag    (cnt_r),
    .out_valid (pv_s),
    .out_tag   (ptag_s),
    .out_p     (pprod_s)
  );

  // Lane registers: capture tagged products; cleared once the result returns
  // so that unused lanes of a short vector read as 0.0.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r <= '0;
    end else if (state_r == ST_DONE) begin
      lane_r <= '0;
    end else if (pv_s) begin
      lane_r[ptag_s] <= pprod_s;
    end else begin
      lane_r <= lane_r;
    end
  end

  // Batch FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_LOAD;
      cnt_r     <= '0;
      drain_r   <= '0;
      last_r    <= 1'b0;
      in_ready  <= 1'b1;
      mult_out  <= '0;
      mult_wen  <= 1'b0;
      acc_start <= 1'b0;
      res_out   <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      // The adder re-reads mult_out every loop, so it must be zero except
      // during the single write cycle.
      mult_out  <= '0;
      mult_wen  <= 1'b0;
      acc_start <= 1'b0;
      res_valid <= 1'b0;
      case (state_r)
        ST_LOAD: begin
          if (close_s) begin
            last_r   <= in_last;
            in_ready <= 1'b0;
            drain_r  <= DR_W'(MULT_LAT - 1);
            state_r  <= ST_DRAIN;
          end else if (accept_s) begin
            cnt_r <= cnt_r + TAG_W'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_DRAIN: begin
          // Leaves on the edge that writes the closing pair's product.
          if (drain_r == DR_W'(0)) begin
            state_r <= ST_FIRE;
          end else begin
            drain_r <= drain_r - DR_W'(1);
          end
        end
        ST_FIRE: begin
          mult_out  <= DWIDTH'(lane_r);
          mult_wen  <= 1'b1;
          acc_start <= 1'b1;
          state_r   <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          if (!acc_finish) begin
            state_r <= ST_WAIT_HIGH;
          end else begin
            state_r <= ST_WAIT_LOW;
          end
        end
        ST_WAIT_HIGH: begin
          if (acc_finish) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_WAIT_HIGH;
          end
        end
        ST_DONE: begin
          res_out   <= acc_out;
          res_valid <= 1'b1;
          res_last  <= last_r;
          cnt_r     <= '0;
          in_ready  <= 1'b1;
          state_r   <= ST_LOAD;
        end
        default: begin
          state_r  <= ST_LOAD;
          cnt_r    <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n_mult_feeder.sv
module tb_n_mult_feeder;

  logic         clk;
  logic         rst;
  logic [31:0]  a_in, b_in;
  logic         in_valid, in_last, in_ready;
  logic [255:0] mult_out;
  logic         mult_wen, acc_start, acc_finish;
  logic [31:0]  acc_out, res_out;
  logic         res_valid, res_last;

  n_mult_feeder dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mult_out(mult_out),
    .mult_wen(mult_wen), .acc_start(acc_start), .acc_finish(acc_finish),
    .acc_out(acc_out), .res_out(res_out), .res_valid(res_valid),
    .res_last(res_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- behavioural float model ----------------
  function automatic real s2r(input logic [31:0] x);
    real v;
    if (x[30:23] == 8'd0 || x[30:23] == 8'd255) return 0.0;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(int'(x[30:23])) - 127.0));
    return x[31] ? -v : v;
  endfunction

  // Real -> single, truncating the mantissa.
  function automatic logic [31:0] r2s(input real r);
    real m;
    logic [63:0] d;
    int e;
    logic sg;
    if (r == 0.0) return 32'd0;
    sg = (r < 0.0);
    m = sg ? -r : r;
    d = $realtobits(m);
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {sg, 8'hFF, 23'd0};
    if (e <= 0) return {sg, 31'd0};
    return {sg, e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic sg;
    logic [31:0] r;
    sg = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sg, 31'd0};
    if (a[30:23] == 8'd255 || b[30:23] == 8'd255) return {sg, 8'hFF, 23'd0};
    r = r2s(s2r({1'b0, a[30:0]}) * s2r({1'b0, b[30:0]}));
    return {sg, r[30:0]};
  endfunction

  function automatic logic [31:0] lane_sum(input logic [255:0] l);
    real s;
    s = 0.0;
    for (int i = 0; i < 8; i++) s = s + s2r(l[i*32 +: 32]);
    return r2s(s);
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int k;
    k = $urandom_range(0, 15);
    case (k)
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [255:0] lanes;
    logic [31:0]  sum;
    logic         last;
  } batch_t;

  batch_t       exp_q[$];
  logic [255:0] cur_lanes = '0;
  int           cur_n = 0;
  bit           head_fired = 0;
  bit           in_rst = 0;
  int           accepted = 0, fires = 0, results = 0;
  logic [255:0] last_lanes = '0;
  logic [32:0]  res_log[$];

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      in_rst = 1;
      exp_q.delete();
      cur_lanes = '0;
      cur_n = 0;
      head_fired = 0;
    end else begin
      if (in_rst) begin
        in_rst = 0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mult_wen", mult_wen, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_last", res_last, 0);
        chk("rst_res_out", res_out, 0);
        chk("rst_mult_out", mult_out, 0);
      end
      chk("wen_eq_start", mult_wen, acc_start);
      if (mult_wen) begin
        chk("fire_expected", (exp_q.size() != 0) && !head_fired, 1);
        if (exp_q.size() != 0) begin
          for (int i = 0; i < 8; i++)
            chk($sformatf("lane%0d", i), mult_out[i*32 +: 32], exp_q[0].lanes[i*32 +: 32]);
        end
        head_fired = 1;
        fires++;
        last_lanes = mult_out;
      end else begin
        chk("mult_out_idle", mult_out, 0);
      end
      if (res_valid) begin
        chk("result_expected", (exp_q.size() != 0) && head_fired, 1);
        if (exp_q.size() != 0) begin
          chk("res_out", res_out, exp_q[0].sum);
          chk("res_last", res_last, exp_q[0].last);
          void'(exp_q.pop_front());
        end
        head_fired = 0;
        results++;
        res_log.push_back({res_last, res_out});
      end
      chk("in_ready", in_ready, exp_q.size() == 0);
      if (in_valid && in_ready) begin
        cur_lanes[cur_n*32 +: 32] = model_mul(a_in, b_in);
        cur_n++;
        accepted++;
        if (in_last || cur_n == 8) begin
          exp_q.push_back('{lanes: cur_lanes, sum: lane_sum(cur_lanes), last: in_last});
          cur_lanes = '0;
          cur_n = 0;
        end
      end
    end
  end

  // Behavioural adder array: busy (finish low) for a while after acc_start.
  int adder_delay = 2;
  bit adder_rand = 0;
  initial begin
    logic [31:0] s;
    acc_finish = 1'b1;
    acc_out = 32'd0;
    forever begin
      @(negedge clk);
      if (acc_start && !rst) begin
        s = lane_sum(mult_out);
        @(posedge clk);
        #1 acc_finish = 1'b0;
        repeat ((adder_rand ? $urandom_range(0, 4) : adder_delay) + 1) @(posedge clk);
        #1;
        acc_out = s;
        acc_finish = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input logic last);
    int n;
    bit done;
    n = 0;
    done = 0;
    a_in = a; b_in = b; in_last = last; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
      if (n > 2000) done = 1;
    end
    chk("accept_in_time", n <= 2000, 1);
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    in_valid = 1'b0;
    in_last = 1'b0;
    while ((exp_q.size() != 0 || cur_n != 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("idle_in_time", n < 5000, 1);
    #1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, r0, a0;
    logic [255:0] e256;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Model pins
    chk("pin_mul_1x2", model_mul(32'h3F800000, 32'h40000000), 32'h40000000);
    chk("pin_mul_3xm2", model_mul(32'h40400000, 32'hC0000000), 32'hC0C00000);
    chk("pin_mul_ovf", model_mul(32'h7F000000, 32'h7F000000), 32'h7F800000);
    chk("pin_sum16", r2s(16.0), 32'h41800000);

    // 8 x (1.0*2.0)
    for (int i = 0; i < 8; i++) send_pair(32'h3F800000, 32'h40000000, i == 7);
    idle_wait();
    chk("t1_lane7", last_lanes[255:224], 32'h40000000);
    chk("t1_res", res_log[$], {1'b1, 32'h41800000});

    // 3 x (3.0*-2.0)
    for (int i = 0; i < 3; i++) send_pair(32'h40400000, 32'hC0000000, i == 2);
    idle_wait();
    e256 = '0;
    for (int i = 0; i < 3; i++) e256[i*32 +: 32] = 32'hC0C00000;
    chk("t2_lanes", last_lanes, e256);
    chk("t2_res", res_log[$], {1'b1, 32'hC1900000});

    // 10 pairs, last only on 10th: two batches
    f0 = fires;
    for (int i = 0; i < 10; i++) send_pair(32'h3F800000, 32'h3F800000, i == 9);
    idle_wait();
    chk("t3_fires", fires - f0, 2);
    chk("t3_res_a", res_log[$-1], {1'b0, 32'h41000000});
    chk("t3_res_b", res_log[$], {1'b1, 32'h40000000});

    // Edge operands, single-pair batches
    send_pair(32'h7F000000, 32'h7F000000, 1'b1); idle_wait();
    chk("edge_ovf", last_lanes[31:0], 32'h7F800000);
    send_pair(32'h00400000, 32'h3F800000, 1'b1); idle_wait();
    chk("edge_denorm", last_lanes[31:0], 32'h00000000);
    send_pair(32'h80000000, 32'h40000000, 1'b1); idle_wait();
    chk("edge_negzero", last_lanes[31:0], 32'h80000000);

    // Backpressure: slow adder, in_valid held high
    adder_delay = 50;
    f0 = fires; r0 = results; a0 = accepted;
    for (int i = 0; i < 20; i++) send_pair(rand_op(), rand_op(), i == 19);
    idle_wait();
    chk("bp_accepted", accepted - a0, 20);
    chk("bp_fires", fires - f0, 3);
    chk("bp_results", results - r0, 3);
    adder_delay = 2;

    // Reset while draining
    f0 = fires;
    for (int i = 0; i < 8; i++) send_pair(32'h3F800000, 32'h40000000, i == 7);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_fire", fires - f0, 0);
    for (int i = 0; i < 3; i++) send_pair(32'h40400000, 32'hC0000000, i == 2);
    idle_wait();
    chk("post_rst_short", res_log[$], {1'b1, 32'hC1900000});
    for (int i = 0; i < 8; i++) send_pair(32'h3F800000, 32'h40000000, i == 7);
    idle_wait();
    chk("post_rst_full", res_log[$], {1'b1, 32'h41800000});

    // Randomised stream
    adder_rand = 1;
    for (int i = 0; i < 60; i++) begin
      send_pair(rand_op(), rand_op(), (i == 59) || ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idle_wait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
